// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: RAW-hazard scoreboard with one saturating pending-write counter per GPR,
// issue squash, fence/drain FSM and sticky error flags. Define HAZARD_BYPASS_EN to clear hazards in the WB cycle.
module scoreboard_ctrl #(
   parameter int NbGpr       = 32,
   parameter int RfAddrWidth = $clog2(NbGpr),
   parameter int BusyWidth   = 2,
   parameter int NbSrc       = 2,
   parameter int NbWb        = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         issue_valid_i,
   input  logic                         issue_ready_i,
   input  logic                         issue_rd_we_i,
   input  logic [RfAddrWidth-1:0]       issue_rd_i,
   input  logic                         flush_i,
   input  logic [NbSrc*RfAddrWidth-1:0] src_addr_i,
   output logic [NbSrc-1:0]             src_dirty_o,
   output logic                         stall_o,
   input  logic [NbWb-1:0]              wb_valid_i,
   input  logic [NbWb*RfAddrWidth-1:0]  wb_rd_i,
   input  logic                         fence_req_i,
   output logic                         fence_ack_o,
   output logic                         busy_o,
   output logic [1:0]                   err_o
);

   localparam int CntMax = 2**BusyWidth - 1;
   localparam int DecW   = $clog2(NbWb + 1);
   localparam int SumW   = BusyWidth + DecW + 2;
   localparam logic signed [SumW-1:0] CntMaxS = SumW'(CntMax);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ACK} state_t;

   state_t                    r_state, w_state_nxt;
   logic [BusyWidth-1:0]      r_cnt [NbGpr];
   logic [1:0]                r_err;
   logic [DecW-1:0]           w_dec [NbGpr];
   logic signed [SumW-1:0]    w_sum [NbGpr];
   logic [BusyWidth-1:0]      w_cnt_nxt [NbGpr];
   logic [NbGpr-1:0]          w_inc, w_udf, w_ovf;
   logic [RfAddrWidth-1:0]    w_src_addr [NbSrc];
   logic                      w_busy, w_rd_sat, w_alloc;

   // Clamp a signed counter update back into the 0..CntMax range.
   function automatic logic [BusyWidth-1:0] sat_cnt(input logic signed [SumW-1:0] v);
      if (v < 0)
         sat_cnt = '0;
      else if (v > CntMaxS)
         sat_cnt = '1;
      else
         sat_cnt = v[BusyWidth-1:0];
   endfunction

   always_comb begin
      for (int r = 0; r < NbGpr; r++) begin
         w_dec[r] = '0;
         for (int p = 0; p < NbWb; p++) begin
            if (r != 0 && wb_valid_i[p] &&
                wb_rd_i[p*RfAddrWidth +: RfAddrWidth] == RfAddrWidth'(r))
               w_dec[r] = w_dec[r] + DecW'(1);
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int r = 0; r < NbGpr; r++) begin
         if (r_cnt[r] != '0)
            w_busy = 1'b1;
      end
   end

   // Source hazard lookup is purely combinational from the current counters.
   always_comb begin
      for (int k = 0; k < NbSrc; k++) begin
         w_src_addr[k]  = src_addr_i[k*RfAddrWidth +: RfAddrWidth];
         src_dirty_o[k] = (w_src_addr[k] != '0) && (r_cnt[w_src_addr[k]] != '0);
`ifdef HAZARD_BYPASS_EN
         if (int'(r_cnt[w_src_addr[k]]) == int'(w_dec[w_src_addr[k]]))
            src_dirty_o[k] = 1'b0;
`endif
      end
   end

   assign w_rd_sat = issue_valid_i & issue_rd_we_i & (&r_cnt[issue_rd_i]);
   assign stall_o  = (|src_dirty_o) | w_rd_sat | (r_state != ST_IDLE);
   assign w_alloc  = issue_valid_i & issue_ready_i & ~stall_o & ~flush_i &
                     issue_rd_we_i & (issue_rd_i != '0);

   always_comb begin
      w_udf = '0;
      w_ovf = '0;
      for (int r = 0; r < NbGpr; r++) begin
         w_inc[r]     = w_alloc && (issue_rd_i == RfAddrWidth'(r));
         w_sum[r]     = $signed(SumW'(r_cnt[r])) + $signed(SumW'(w_inc[r])) -
                        $signed(SumW'(w_dec[r]));
         w_cnt_nxt[r] = sat_cnt(w_sum[r]);
         w_udf[r]     = (w_sum[r] < 0);
         w_ovf[r]     = (w_sum[r] > CntMaxS);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NbGpr; r++)
            r_cnt[r] <= '0;
         r_err   <= '0;
         r_state <= ST_IDLE;
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NbGpr; r++)
            r_cnt[r] <= w_cnt_nxt[r];
         r_err   <= r_err | {(|w_ovf), (|w_udf)};
         r_state <= w_state_nxt;
      end
   end

   // Fence: a request is latched into DRAIN; ACK follows once the table is seen empty.
   always_comb begin
      w_state_nxt = r_state;
      fence_ack_o = 1'b0;
      case (r_state)
         ST_IDLE:  if (fence_req_i) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (!w_busy) w_state_nxt = ST_ACK;
         ST_ACK: begin
            fence_ack_o = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy_o = w_busy;
   assign err_o  = r_err;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Bench for scoreboard_ctrl (NbWb=2): a behavioural model predicts each cycle's outputs into a queue,
// and every test task pops and compares them against the DUT.
module tb_scoreboard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0, issue_ready = 1'b0, issue_rd_we = 1'b0, flush = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [9:0]  src_addr = '0;
   logic [1:0]  src_dirty;
   logic        stall, fence_ack, busy;
   logic [1:0]  wb_valid = '0;
   logic [9:0]  wb_rd = '0;
   logic        fence_req = 1'b0;
   logic [1:0]  err;
   logic [6:0]  got, exp_v;

   always #5 clk = ~clk;

   scoreboard_ctrl #(.NbGpr(32), .BusyWidth(2), .NbSrc(2), .NbWb(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_ready_i(issue_ready), .issue_rd_we_i(issue_rd_we),
      .issue_rd_i(issue_rd), .flush_i(flush), .src_addr_i(src_addr),
      .src_dirty_o(src_dirty), .stall_o(stall),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
      .fence_req_i(fence_req), .fence_ack_o(fence_ack), .busy_o(busy), .err_o(err)
   );

   assign got = {src_dirty, stall, busy, fence_ack, err};

   typedef struct packed {
      logic       iv; logic we; logic [4:0] rd; logic fl; logic rdy;
      logic [4:0] s1; logic [4:0] s0;
      logic [1:0] wv; logic [4:0] w1; logic [4:0] w0; logic fr;
   } row_t;

   logic [6:0] q_exp [$];
   int n_checks = 0;
   int n_errors = 0;

   int         m_cnt [32];
   int         m_cnt_n [32];
   int         m_state, m_state_n;   // 0 idle, 1 drain, 2 ack
   logic [1:0] m_err, m_err_n;

   function automatic row_t mk(input logic iv, input logic we, input logic [4:0] rd, input logic fl,
                               input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] wv,
                               input logic [4:0] w1, input logic [4:0] w0, input logic fr);
      row_t x;
      x.iv = iv; x.we = we; x.rd = rd; x.fl = fl; x.rdy = 1'b1;
      x.s1 = s1; x.s0 = s0; x.wv = wv; x.w1 = w1; x.w0 = w0; x.fr = fr;
      return x;
   endfunction

   function automatic int mdec(input int r);
      int d = 0;
      if (r == 0) return 0;
      if (wb_valid[0] && int'(wb_rd[4:0]) == r) d++;
      if (wb_valid[1] && int'(wb_rd[9:5]) == r) d++;
      return d;
   endfunction

   function automatic logic mdirty(input logic [4:0] a);
      if (a == 0 || m_cnt[a] == 0) return 1'b0;
`ifdef HAZARD_BYPASS_EN
      if (m_cnt[a] == mdec(int'(a))) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = 0;
         m_cnt_n[i] = 0;
      end
      m_state = 0; m_state_n = 0;
      m_err = '0;  m_err_n = '0;
   endtask

   // One cycle: drive at negedge, predict outputs and next model state, leave time in the sample window.
   task automatic tick(input row_t r);
      logic [1:0] d;
      logic       sat, stl, bsy, alloc;
      int         v;
      @(negedge clk);
      m_cnt = m_cnt_n; m_state = m_state_n; m_err = m_err_n;
      issue_valid = r.iv; issue_ready = r.rdy; issue_rd_we = r.we; issue_rd = r.rd; flush = r.fl;
      src_addr = {r.s1, r.s0}; wb_valid = r.wv; wb_rd = {r.w1, r.w0}; fence_req = r.fr;
      d   = {mdirty(r.s1), mdirty(r.s0)};
      sat = r.iv && r.we && (m_cnt[r.rd] == 3);
      stl = (d != 2'b00) || sat || (m_state != 0);
      bsy = 1'b0;
      for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) bsy = 1'b1;
      q_exp.push_back({d, stl, bsy, (m_state == 2), m_err});
      alloc = r.iv && r.rdy && !stl && !r.fl && r.we && (r.rd != 0);
      m_err_n = m_err;
      for (int i = 0; i < 32; i++) begin
         v = m_cnt[i] - mdec(i);
         if (alloc && int'(r.rd) == i) v++;
         if (v < 0) begin v = 0; m_err_n[0] = 1'b1; end
         if (v > 3) begin v = 3; m_err_n[1] = 1'b1; end
         m_cnt_n[i] = v;
      end
      case (m_state)
         0:       m_state_n = r.fr ? 1 : 0;
         1:       m_state_n = bsy ? 1 : 2;
         default: m_state_n = 0;
      endcase
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      rst = 1'b1;
      src_addr = {5'd2, 5'd1};
      model_reset();
      #1;
      n_checks++;
      if (got !== 7'b0) begin
         n_errors++;
         $display("FAIL reset: got dirty/stall/busy/ack/err=%b, expected %b", got, 7'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      rows.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL reset_idle[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_alloc_visibility();
      row_t rows[$];
      rows.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0));   // alloc x5
      rows.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 0));   // src x5 dirty
      rows.push_back(mk(0, 0, 0, 0, 0, 5, 2'b01, 0, 5, 0)); // WB x5
      rows.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL alloc_vis[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      row_t rows[$];
      repeat (3) rows.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0));       // saturated: stall
      rows.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 7, 0, 0, 0, 2'b01, 0, 7, 0));   // stalled issue + WB
      rows.push_back(mk(1, 1, 7, 0, 0, 0, 2'b01, 0, 7, 0));   // alloc + WB, unchanged
      rows.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0));       // saturated again
      rows.push_back(mk(0, 0, 0, 0, 7, 0, 2'b11, 7, 7, 0));
      rows.push_back(mk(0, 0, 0, 0, 7, 0, 2'b10, 7, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 7, 7, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL saturation[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_dual_wb_underflow();
      row_t rows[$];
      rows.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 9, 0, 2'b11, 9, 9, 0));   // two retires, one pending
      rows.push_back(mk(0, 0, 0, 0, 9, 9, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));   // x0 retire ignored
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL dual_wb[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_fence();
      row_t rows[$];
      rows.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));       // fence request pulse
      rows.push_back(mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0));      // blocked by drain
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 3, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 4, 0, 0));
      repeat (3) rows.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));       // empty fence
      repeat (4) rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL fence[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_flush();
      row_t rows[$];
      row_t x;
      rows.push_back(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0));       // squashed
      rows.push_back(mk(0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
      x = mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      x.rdy = 1'b0;                                           // not accepted downstream
      rows.push_back(x);
      rows.push_back(mk(0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 0));       // no rd write
      rows.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0));       // real alloc
      rows.push_back(mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 0));       // flush leaves it pending
      rows.push_back(mk(0, 0, 0, 0, 6, 0, 2'b10, 6, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL flush[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_reset_in_drain();
      row_t rows[$];
      row_t post[$];
      rows.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL drain_pre[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (got !== 7'b0) begin
         n_errors++;
         $display("FAIL drain_reset: got %b, expected %b", got, 7'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) post.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      foreach (post[i]) begin
         tick(post[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL drain_post[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      row_t x;
      for (int n = 0; n < 80; n++) begin
         x = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)),
                1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
                1'($urandom_range(0, 15) == 0));
         x.rdy = 1'($urandom_range(0, 4) != 0);
         rows.push_back(x);
      end
      foreach (rows[i]) begin
         tick(rows[i]);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL back_to_back[%0d]: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alloc_visibility();
      test_saturation();
      test_dual_wb_underflow();
      test_fence();
      test_flush();
      test_reset_in_drain();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
